// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle FSM that sequences an RV64I datapath (PC, IR, register file,
//   ALU, memory port). It fetches an instruction, latches the decoder fields
//   in DECODE, and drives the per-state datapath enables. It also counts
//   retired instructions. It traps on an illegal opcode or on a memory
//   access that does not complete within MEM_TIMEOUT cycles.
//
// Memory handshake: mem_re / mem_we is a request that stays high, unchanged,
//   in FETCH/MEM until the cycle in which mem_ready=1. The access completes
//   in that same cycle. mem_ready is ignored while no request is raised.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 leave IDLE (ignored elsewhere)
//   op_code/funct3/funct7 decoder fields taken from IR
//   alu_zero              ALU result is zero (branch resolution in EXEC)
//   mem_ready             memory completes the pending access this cycle
//   mem_re, mem_we        memory read / write request
//   ir_we, pc_we, pc_src  IR load, PC write, PC source (0 PC+4, 1 target)
//   reg_we, wb_sel        register write, writeback source (1 = memory)
//   alu_src, alu_op       ALU operand B select, ALU operation
//   busy, trap, trap_cause status (cause 01 illegal opcode, 10 timeout)
//   instr_retired         retired-instruction counter (wraps)
//   dbg_state, dbg_fields current FSM state and latched {op, funct3, funct7}
module multicycle_control_unit #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [6:0]           op_code,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_src,
    output logic                 reg_we,
    output logic                 alu_src,
    output logic [3:0]           alu_op,
    output logic                 wb_sel,
    output logic                 busy,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instr_retired,
    output logic [2:0]           dbg_state,
    output logic [16:0]          dbg_fields
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int            TW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(MEM_TIMEOUT - 1);

    state_t         state, state_nx;
    logic [6:0]     lat_op;
    logic [2:0]     lat_f3;
    logic [6:0]     lat_f7;
    logic [TW-1:0]  tcnt;
    logic [1:0]     cause;
    logic           waiting, timeout, taken, retire, supported;

    // funct3 -> ALU op. alt (funct7[5]) selects SUB only for R-type,
    // and SRA over SRL for both R and I-ALU.
    function automatic logic [3:0] alu_map(input logic [2:0] f3,
                                           input logic       alt,
                                           input logic       is_r);
        logic [3:0] r;
        r = 4'd0;
        case (f3)
            3'b000:  r = (alt && is_r) ? 4'd1 : 4'd0;
            3'b001:  r = 4'd5;
            3'b010:  r = 4'd8;
            3'b011:  r = 4'd9;
            3'b100:  r = 4'd4;
            3'b101:  r = alt ? 4'd7 : 4'd6;
            3'b110:  r = 4'd3;
            default: r = 4'd2;
        endcase
        return r;
    endfunction

    always_comb begin
        supported = (op_code == OP_R) || (op_code == OP_I) || (op_code == OP_LOAD) ||
                    (op_code == OP_STORE) || (op_code == OP_BRANCH);
        waiting   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
        // mem_ready in the limit cycle wins: waiting is false then.
        timeout   = waiting && (tcnt == TLIM);
        taken     = ((lat_f3 == 3'b000) && alu_zero) || ((lat_f3 == 3'b001) && !alu_zero);
        retire    = ((state == S_EXEC) && (lat_op == OP_BRANCH)) ||
                    ((state == S_MEM) && (lat_op == OP_STORE) && mem_ready) ||
                    (state == S_WB);
    end

    // State register and datapath-side bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            lat_op        <= '0;
            lat_f3        <= '0;
            lat_f7        <= '0;
            tcnt          <= '0;
            cause         <= 2'b00;
            instr_retired <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                lat_op <= op_code;
                lat_f3 <= funct3;
                lat_f7 <= funct7;
            end
            // Counter is zero whenever no access is stalled, so every entry
            // into FETCH/MEM starts from zero.
            tcnt <= waiting ? tcnt + TW'(1) : '0;
            if (state == S_DECODE && !supported) cause <= 2'b01;
            else if (timeout)                    cause <= 2'b10;
            if (retire) instr_retired <= instr_retired + CNT_WIDTH'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH:  begin
                if (mem_ready)    state_nx = S_DECODE;
                else if (timeout) state_nx = S_TRAP;
            end
            S_DECODE: state_nx = supported ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (lat_op == OP_BRANCH)                           state_nx = S_FETCH;
                else if (lat_op == OP_LOAD || lat_op == OP_STORE) state_nx = S_MEM;
                else                                               state_nx = S_WB;
            end
            S_MEM: begin
                if (mem_ready)    state_nx = (lat_op == OP_STORE) ? S_FETCH : S_WB;
                else if (timeout) state_nx = S_TRAP;
            end
            S_WB:     state_nx = S_FETCH;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output logic: state plus latched fields; FETCH/MEM completion and
    // branch resolution also look at mem_ready / alu_zero.
    always_comb begin
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 4'd0;
        wb_sel     = 1'b0;
        busy       = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                     (state == S_MEM) || (state == S_WB);
        trap       = (state == S_TRAP);
        trap_cause = cause;
        dbg_state  = state;
        dbg_fields = {lat_op, lat_f3, lat_f7};
        case (state)
            S_FETCH: begin
                mem_re = 1'b1;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            S_EXEC: begin
                case (lat_op)
                    OP_R:      alu_op = alu_map(lat_f3, lat_f7[5], 1'b1);
                    OP_I: begin
                        alu_src = 1'b1;
                        alu_op  = alu_map(lat_f3, lat_f7[5], 1'b0);
                    end
                    OP_LOAD, OP_STORE: alu_src = 1'b1;
                    OP_BRANCH: begin
                        alu_op = 4'd1;
                        pc_we  = taken;
                        pc_src = taken;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_re = (lat_op == OP_LOAD);
                mem_we = (lat_op == OP_STORE);
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = (lat_op == OP_LOAD);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_zero;
    logic        mem_ready;

    logic        mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src, wb_sel, busy, trap;
    logic [3:0]  alu_op;
    logic [1:0]  trap_cause;
    logic [31:0] instr_retired;
    logic [2:0]  dbg_state;
    logic [16:0] dbg_fields;

    logic        mem_re_b, mem_we_b, ir_we_b, pc_we_b, pc_src_b, reg_we_b, alu_src_b, wb_sel_b;
    logic        busy_b, trap_b;
    logic [3:0]  alu_op_b;
    logic [1:0]  trap_cause_b;
    logic [1:0]  instr_retired_b;
    logic [2:0]  dbg_state_b;
    logic [16:0] dbg_fields_b;

    int n_vec = 0;
    int n_err = 0;
    int exp_ret = 0;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    multicycle_control_unit #(.CNT_WIDTH(32), .MEM_TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code), .funct3(funct3),
        .funct7(funct7), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .alu_src(alu_src), .alu_op(alu_op), .wb_sel(wb_sel), .busy(busy),
        .trap(trap), .trap_cause(trap_cause), .instr_retired(instr_retired),
        .dbg_state(dbg_state), .dbg_fields(dbg_fields)
    );

    // Narrow-counter copy sharing all stimulus, used for the wrap check.
    multicycle_control_unit #(.CNT_WIDTH(2), .MEM_TIMEOUT(16)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code), .funct3(funct3),
        .funct7(funct7), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_re(mem_re_b), .mem_we(mem_we_b), .ir_we(ir_we_b), .pc_we(pc_we_b),
        .pc_src(pc_src_b), .reg_we(reg_we_b), .alu_src(alu_src_b), .alu_op(alu_op_b),
        .wb_sel(wb_sel_b), .busy(busy_b), .trap(trap_b), .trap_cause(trap_cause_b),
        .instr_retired(instr_retired_b), .dbg_state(dbg_state_b), .dbg_fields(dbg_fields_b)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] all_outs();
        return {mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src, alu_op, wb_sel,
                busy, trap, trap_cause};
    endfunction

    // Reset, check the quiet state, then start so the DUT sits in FETCH.
    task automatic reset_and_start();
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
        op_code = '0; funct3 = '0; funct7 = '0;
        exp_ret = 0;
        repeat (2) tick();
        check("rst_outs", 32'(all_outs()), 32'h0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_retired", instr_retired, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(dbg_state), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_fetch", 32'(dbg_state), 32'd1);
    endtask

    // Runs one instruction starting in FETCH and checks each state's enables.
    task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic zero, input int fwait,
                            input int mwait, input logic [3:0] e_alu, input logic e_src,
                            input logic e_taken);
        logic is_ld, is_st, is_br;
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        is_br = (op == OP_BRANCH);
        op_code = op; funct3 = f3; funct7 = f7; alu_zero = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < fwait; i++) begin
            #1;
            check({tag, ":fetch_wait"}, 32'({mem_re, ir_we, pc_we, dbg_state}), 32'({3'b100, 3'd1}));
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check({tag, ":fetch"}, 32'({mem_re, ir_we, pc_we, pc_src, busy}), 32'b11101);
        tick();
        mem_ready = 1'b0;
        #1;
        check({tag, ":decode"}, 32'({dbg_state, mem_re, ir_we, pc_we, reg_we}), 32'({3'd2, 4'b0}));
        tick();
        // Scramble decoder inputs: EXEC must work from the latched copies.
        op_code = 7'b1111111; funct3 = ~f3; funct7 = ~f7; alu_zero = zero;
        #1;
        check({tag, ":latched"}, 32'(dbg_fields), 32'({op, f3, f7}));
        check({tag, ":exec"}, 32'({dbg_state, alu_op, alu_src}), 32'({3'd3, e_alu, e_src}));
        if (is_br)
            check({tag, ":branch_pc"}, 32'({pc_we, pc_src}), 32'({e_taken, e_taken}));
        tick();
        alu_zero = 1'b0;
        if (is_ld || is_st) begin
            for (int i = 0; i < mwait; i++) begin
                #1;
                check({tag, ":mem_wait"}, 32'({dbg_state, mem_re, mem_we}), 32'({3'd4, is_ld, is_st}));
                tick();
            end
            mem_ready = 1'b1;
            #1;
            check({tag, ":mem"}, 32'({dbg_state, mem_re, mem_we}), 32'({3'd4, is_ld, is_st}));
            tick();
            mem_ready = 1'b0;
        end
        if (!is_br && !is_st) begin
            #1;
            check({tag, ":wb"}, 32'({dbg_state, reg_we, wb_sel}), 32'({3'd5, 1'b1, is_ld}));
            check({tag, ":wb_not_yet_retired"}, instr_retired, 32'(exp_ret));
            tick();
        end
        exp_ret++;
        #1;
        check({tag, ":retired"}, instr_retired, 32'(exp_ret));
        check({tag, ":retired_w2"}, 32'(instr_retired_b), 32'(exp_ret % 4));
        check({tag, ":back_to_fetch"}, 32'({dbg_state, mem_re}), 32'({3'd1, 1'b1}));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
        op_code = '0; funct3 = '0; funct7 = '0;

        reset_and_start();
        // Five retirements also walk the 2-bit counter through 1,2,3,0,1.
        do_instr("add",  OP_R,     3'b000, 7'b0000000, 1'b0, 0, 0, 4'd0, 1'b0, 1'b0);
        do_instr("sub",  OP_R,     3'b000, 7'b0100000, 1'b0, 0, 0, 4'd1, 1'b0, 1'b0);
        do_instr("srai", OP_I,     3'b101, 7'b0100000, 1'b0, 0, 0, 4'd7, 1'b1, 1'b0);
        do_instr("load", OP_LOAD,  3'b011, 7'b0000000, 1'b0, 0, 3, 4'd0, 1'b1, 1'b0);
        do_instr("store",OP_STORE, 3'b011, 7'b0000000, 1'b0, 0, 1, 4'd0, 1'b1, 1'b0);
        do_instr("beq",  OP_BRANCH,3'b000, 7'b0000000, 1'b1, 0, 0, 4'd1, 1'b0, 1'b1);
        do_instr("bne",  OP_BRANCH,3'b001, 7'b0000000, 1'b1, 0, 0, 4'd1, 1'b0, 1'b0);
        do_instr("blt",  OP_BRANCH,3'b100, 7'b0000000, 1'b1, 0, 0, 4'd1, 1'b0, 1'b0);
        do_instr("addi_f7", OP_I,  3'b000, 7'b0100000, 1'b0, 0, 0, 4'd0, 1'b1, 1'b0);
        do_instr("xori", OP_I,     3'b100, 7'b0100000, 1'b0, 1, 0, 4'd4, 1'b1, 1'b0);
        do_instr("sltu", OP_R,     3'b011, 7'b0000000, 1'b0, 0, 0, 4'd9, 1'b0, 1'b0);
        do_instr("srl",  OP_R,     3'b101, 7'b0000000, 1'b0, 0, 0, 4'd6, 1'b0, 1'b0);

        // Illegal opcode after a delayed fetch.
        op_code = 7'b1111111; funct3 = 3'b000; funct7 = 7'b0;
        mem_ready = 1'b0;
        repeat (2) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        check("illegal_trap", 32'({dbg_state, trap, busy, trap_cause}), 32'({3'd6, 1'b1, 1'b0, 2'b01}));
        check("illegal_quiet", 32'({mem_re, mem_we, ir_we, pc_we, reg_we}), 32'h0);
        check("illegal_not_retired", instr_retired, 32'(exp_ret));
        start = 1'b1; mem_ready = 1'b1;
        repeat (3) tick();
        start = 1'b0; mem_ready = 1'b0;
        check("trap_sticky", 32'({dbg_state, trap_cause}), 32'({3'd6, 2'b01}));
        rst_n = 1'b0;
        #1;
        check("trap_rst_outs", 32'(all_outs()), 32'h0);
        check("trap_rst_retired", instr_retired, 32'd0);

        // Fetch timeout: 15 stalled cycles stay in FETCH, the 16th traps.
        reset_and_start();
        mem_ready = 1'b0;
        repeat (15) tick();
        check("to_still_fetch", 32'({dbg_state, mem_re}), 32'({3'd1, 1'b1}));
        tick();
        check("to_trap", 32'({dbg_state, trap, trap_cause, mem_re}), 32'({3'd6, 1'b1, 2'b10, 1'b0}));

        // mem_ready arriving in the limit cycle completes normally.
        reset_and_start();
        do_instr("add_f15",   OP_R,     3'b000, 7'b0000000, 1'b0, 15, 0,  4'd0, 1'b0, 1'b0);
        do_instr("store_m15", OP_STORE, 3'b010, 7'b0000000, 1'b0, 0,  15, 4'd0, 1'b1, 1'b0);

        // Reset while a store waits in MEM drops mem_we at once.
        op_code = OP_STORE; funct3 = 3'b010; funct7 = 7'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (2) tick();
        check("abort_mem_we", 32'({dbg_state, mem_we}), 32'({3'd4, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("abort_now", 32'({dbg_state, mem_we, busy}), 32'({3'd0, 1'b0, 1'b0}));
        mem_ready = 1'b1;
        tick();
        check("abort_no_retire", instr_retired, 32'd0);
        mem_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
